// File: rtl/microseq_pkg.sv
// Shared encodings and field widths for the microsequencer.
// Holds sequencing codes, CALL/RET qualifiers, FSM states and the issued-field bundle.
package microseq_pkg;

    localparam int ALU_W   = 4;
    localparam int SH_W    = 2;
    localparam int KMX_W   = 1;
    localparam int M_W     = 2;
    localparam int SRC_W   = 6;
    localparam int T_W     = 7;
    localparam int A_W     = 5;
    localparam int DADDR_W = 11;

    typedef enum logic [1:0] {
        SEQ_NEXT   = 2'b00,
        SEQ_JUMP   = 2'b01,
        SEQ_BRANCH = 2'b10,
        SEQ_END    = 2'b11
    } seq_e;

    localparam logic [1:0] COND_CALL = 2'b01;
    localparam logic [1:0] COND_RET  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [ALU_W-1:0]   alu;
        logic [SH_W-1:0]    sh;
        logic [KMX_W-1:0]   kmx;
        logic [M_W-1:0]     m;
        logic [SRC_W-1:0]   b;
        logic [SRC_W-1:0]   c;
        logic [T_W-1:0]     t;
        logic [A_W-1:0]     a;
        logic [DADDR_W-1:0] daddr;
    } fields_t;

    // A source reads register dest only when it is not a constant (bit5 clear).
    function automatic logic src_reads(
        input logic [SRC_W-1:0] src,
        input logic [A_W-1:0]   dest
    );
        return !src[SRC_W-1] && (src[A_W-1:0] == dest);
    endfunction

endpackage

// File: rtl/microsequencer_if.sv
// Control-store bus between the sequencer (master) and a synchronous ROM (slave).
// Ports: cs_addr from master; fetched word fields cs_* from slave one cycle later.
interface microsequencer_if #(
    parameter int UPC_W = 8
);
    import microseq_pkg::*;

    logic [UPC_W-1:0]   cs_addr;
    logic [ALU_W-1:0]   cs_alu;
    logic [SH_W-1:0]    cs_sh;
    logic [KMX_W-1:0]   cs_kmx;
    logic [M_W-1:0]     cs_m;
    logic [SRC_W-1:0]   cs_b;
    logic [SRC_W-1:0]   cs_c;
    logic [T_W-1:0]     cs_t;
    logic [A_W-1:0]     cs_a;
    logic [DADDR_W-1:0] cs_daddr;
    logic [1:0]         cs_seq;
    logic [1:0]         cs_cond;
    logic [UPC_W-1:0]   cs_target;

    modport master (
        output cs_addr,
        input  cs_alu, cs_sh, cs_kmx, cs_m, cs_b, cs_c,
        input  cs_t, cs_a, cs_daddr, cs_seq, cs_cond, cs_target
    );

    modport slave (
        input  cs_addr,
        output cs_alu, cs_sh, cs_kmx, cs_m, cs_b, cs_c,
        output cs_t, cs_a, cs_daddr, cs_seq, cs_cond, cs_target
    );

endinterface

// File: rtl/microseq_hazard.sv
// Combinational RAW detector: sources B/C of the fetched word against in-flight dests.
// Ports: src_b/src_c in, vld/dest in-flight tracker in, stall out.
module microseq_hazard
    import microseq_pkg::*;
#(
    parameter int HAZ_STAGES = 2
) (
    input  logic [SRC_W-1:0]                src_b,
    input  logic [SRC_W-1:0]                src_c,
    input  logic [HAZ_STAGES-1:0]           vld,
    input  logic [HAZ_STAGES-1:0][A_W-1:0]  dest,
    output logic                            stall
);

    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < HAZ_STAGES; i++) begin
            if (vld[i] && (dest[i] != '0) &&
                (src_reads(src_b, dest[i]) || src_reads(src_c, dest[i]))) begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Control-store sequencer: fetches microwords, issues them to stage 1 with RAW bubbles.
// Ports: clock/reset_n, start/start_addr, cs bus (master), cond_flags, issued fields,
// issue_valid, busy, done, err. Optional return stack under MICROSEQ_STACK_EN.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int UPC_W       = 8,
    parameter int HAZ_STAGES  = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [UPC_W-1:0]    start_addr,
    microsequencer_if.master    cs,
    input  logic [3:0]          cond_flags,
    output logic [ALU_W-1:0]    ALU_IN,
    output logic [SH_W-1:0]     SH_IN,
    output logic [KMX_W-1:0]    KMx_IN,
    output logic [M_W-1:0]      M_IN,
    output logic [SRC_W-1:0]    B_IN,
    output logic [SRC_W-1:0]    C_IN,
    output logic [T_W-1:0]      T_IN,
    output logic [A_W-1:0]      A_IN,
    output logic [DADDR_W-1:0]  data_address_in,
    output logic                issue_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [UPC_W-1:0] UPC_ONE = UPC_W'(1);

    state_e                          state_q, state_d;
    logic [UPC_W-1:0]                upc_q, upc_d, nxt;
    fields_t                         out_q, cur;
    logic [HAZ_STAGES-1:0]           vld_q;
    logic [HAZ_STAGES-1:0][A_W-1:0]  dest_q;
    logic                            raw, stall, any_valid;
    logic                            issue, fault;
    seq_e                            seq;

    assign seq = seq_e'(cs.cs_seq);
    assign cur = fields_t'({cs.cs_alu, cs.cs_sh, cs.cs_kmx, cs.cs_m, cs.cs_b,
                            cs.cs_c, cs.cs_t, cs.cs_a, cs.cs_daddr});
    assign any_valid = |vld_q;

    microseq_hazard #(
        .HAZ_STAGES (HAZ_STAGES)
    ) u_hazard (
        .src_b (cs.cs_b),
        .src_c (cs.cs_c),
        .vld   (vld_q),
        .dest  (dest_q),
        .stall (raw)
    );

    // Branches wait for an empty pipe so cond_flags reflect every older word.
    assign stall = raw || ((seq == SEQ_BRANCH) && any_valid);

`ifdef MICROSEQ_STACK_EN
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [UPC_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [IDX_W-1:0] top_idx;
    logic             push, pop, err_q;

    assign top_idx = sp_q[IDX_W-1:0] - IDX_ONE;
    assign err     = err_q;
`else
    wire unused_stack = |STACK_DEPTH;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        upc_d      = upc_q;
        nxt        = upc_q + UPC_ONE;
        cs.cs_addr = upc_q;
        issue      = 1'b0;
        fault      = 1'b0;
`ifdef MICROSEQ_STACK_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cs.cs_addr = start_addr;
                if (start) begin
                    upc_d   = start_addr;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    unique case (seq)
                        SEQ_NEXT: nxt = upc_q + UPC_ONE;
                        SEQ_JUMP: begin
                            nxt = cs.cs_target;
`ifdef MICROSEQ_STACK_EN
                            if (cs.cs_cond == COND_CALL) begin
                                if (sp_q == SP_FULL) fault = 1'b1;
                                else push = 1'b1;
                            end else if (cs.cs_cond == COND_RET) begin
                                if (sp_q == '0) begin
                                    fault = 1'b1;
                                end else begin
                                    pop = 1'b1;
                                    nxt = stack_q[top_idx];
                                end
                            end
`endif
                        end
                        SEQ_BRANCH: begin
                            nxt = cond_flags[cs.cs_cond] ? cs.cs_target
                                                         : upc_q + UPC_ONE;
                        end
                        SEQ_END: nxt = upc_q;
                        default: nxt = upc_q;
                    endcase
                    if (fault) begin
                        state_d = ST_DRAIN;
                    end else begin
                        issue      = 1'b1;
                        upc_d      = nxt;
                        cs.cs_addr = nxt;
                        if (seq == SEQ_END) state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!any_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            upc_q       <= '0;
            out_q       <= '0;
            issue_valid <= 1'b0;
            vld_q       <= '0;
            dest_q      <= '0;
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            out_q       <= issue ? cur : '0;
            issue_valid <= issue;
            for (int i = HAZ_STAGES - 1; i > 0; i--) begin
                vld_q[i]  <= vld_q[i-1];
                dest_q[i] <= dest_q[i-1];
            end
            vld_q[0]  <= issue;
            dest_q[0] <= issue ? cs.cs_a : '0;
        end
    end

`ifdef MICROSEQ_STACK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (fault) err_q <= 1'b1;
            if (push) begin
                stack_q[sp_q[IDX_W-1:0]] <= upc_q + UPC_ONE;
                sp_q <= sp_q + SP_ONE;
            end
            if (pop) sp_q <= sp_q - SP_ONE;
        end
    end
`endif

    assign ALU_IN          = out_q.alu;
    assign SH_IN           = out_q.sh;
    assign KMx_IN          = out_q.kmx;
    assign M_IN            = out_q.m;
    assign B_IN            = out_q.b;
    assign C_IN            = out_q.c;
    assign T_IN            = out_q.t;
    assign A_IN            = out_q.a;
    assign data_address_in = out_q.daddr;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DRAIN) && !any_valid;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: random and directed microprograms in a ROM model.
// A program walker predicts issue order, issue cycle and done cycle.
module tb_microsequencer;
    import microseq_pkg::*;

    localparam int UPC_W = 8;
    localparam int HAZ   = 2;

    typedef struct packed {
        logic [3:0]  alu;
        logic [1:0]  sh;
        logic        kmx;
        logic [1:0]  m;
        logic [5:0]  b;
        logic [5:0]  c;
        logic [6:0]  t;
        logic [4:0]  a;
        logic [10:0] daddr;
        logic [1:0]  seq;
        logic [1:0]  cond;
        logic [7:0]  target;
    } word_t;

    typedef struct {
        word_t w;
        int    rel;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic [3:0]  cond_flags = 4'h0;
    logic [3:0]  ALU_IN;
    logic [1:0]  SH_IN;
    logic        KMx_IN;
    logic [1:0]  M_IN;
    logic [5:0]  B_IN, C_IN;
    logic [6:0]  T_IN;
    logic [4:0]  A_IN;
    logic [10:0] data_address_in;
    logic        issue_valid, busy, done, err;

    microsequencer_if #(.UPC_W(UPC_W)) cs();

    microsequencer #(
        .UPC_W       (UPC_W),
        .HAZ_STAGES  (HAZ),
        .STACK_DEPTH (4)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .start_addr      (start_addr),
        .cs              (cs),
        .cond_flags      (cond_flags),
        .ALU_IN          (ALU_IN),
        .SH_IN           (SH_IN),
        .KMx_IN          (KMx_IN),
        .M_IN            (M_IN),
        .B_IN            (B_IN),
        .C_IN            (C_IN),
        .T_IN            (T_IN),
        .A_IN            (A_IN),
        .data_address_in (data_address_in),
        .issue_valid     (issue_valid),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clock = ~clock;

    word_t rom [256];
    word_t rd_q;

    always @(posedge clock) rd_q <= rom[cs.cs_addr];

    assign cs.cs_alu    = rd_q.alu;
    assign cs.cs_sh     = rd_q.sh;
    assign cs.cs_kmx    = rd_q.kmx;
    assign cs.cs_m      = rd_q.m;
    assign cs.cs_b      = rd_q.b;
    assign cs.cs_c      = rd_q.c;
    assign cs.cs_t      = rd_q.t;
    assign cs.cs_a      = rd_q.a;
    assign cs.cs_daddr  = rd_q.daddr;
    assign cs.cs_seq    = rd_q.seq;
    assign cs.cs_cond   = rd_q.cond;
    assign cs.cs_target = rd_q.target;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   s_cyc = 0;
    int   exp_done_rel = 0;
    logic armed = 1'b0;
    logic done_seen = 1'b0;
    exp_t sbq[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] out_fields();
        return 64'({ALU_IN, SH_IN, KMx_IN, M_IN, B_IN, C_IN, T_IN, A_IN,
                    data_address_in});
    endfunction

    // Monitor: pops one expectation per issued word; bubbles must be all-zero.
    always @(negedge clock) begin
        if (armed && reset_n) begin
            int   rel;
            exp_t e;
            rel = cyc - s_cyc;
            if (issue_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue actual=%0h required=none",
                             out_fields());
                end else begin
                    e = sbq.pop_front();
                    check("issue_fields", out_fields(),
                          64'({e.w.alu, e.w.sh, e.w.kmx, e.w.m, e.w.b, e.w.c,
                               e.w.t, e.w.a, e.w.daddr}));
                    check("issue_cycle", 64'(rel), 64'(e.rel));
                end
            end else begin
                check("bubble_zero", out_fields(), 64'd0);
            end
            if (done) begin
                check("done_cycle", 64'(rel), 64'(exp_done_rel));
                check("done_queue_empty", 64'(sbq.size()), 64'd0);
                done_seen = 1'b1;
            end
        end
    end

    function automatic word_t rand_word(input logic [7:0] addr);
        word_t w;
        w.alu    = 4'($urandom);
        w.sh     = 2'($urandom);
        w.kmx    = 1'($urandom);
        w.m      = 2'($urandom);
        w.b      = 6'($urandom);
        w.c      = 6'($urandom);
        w.t      = 7'($urandom);
        w.a      = 5'($urandom);
        w.daddr  = {3'b000, addr};
        w.seq    = SEQ_END;
        w.cond   = 2'($urandom);
        w.target = 8'($urandom);
        return w;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = rand_word(8'(i));
    endtask

    task automatic put(input logic [7:0] addr, input logic [1:0] seq,
                       input logic [4:0] a, input logic [5:0] b,
                       input logic [5:0] c, input logic [1:0] cond,
                       input logic [7:0] tgt);
        word_t w;
        w        = rand_word(addr);
        w.seq    = seq;
        w.a      = a;
        w.b      = b;
        w.c      = c;
        w.cond   = cond;
        w.target = tgt;
        rom[addr] = w;
    endtask

    function automatic logic [5:0] rand_src();
        return {($urandom_range(0, 3) == 0), 3'b000, 2'($urandom)};
    endfunction

    // Forward-only control flow guarantees every random program reaches END.
    task automatic gen_prog(input logic [7:0] s, input int len);
        clear_rom();
        for (int k = 0; k < len; k++) begin
            logic [7:0] addr;
            word_t      w;
            int         lim, r;
            addr = s + 8'(k);
            w    = rand_word(addr);
            w.a  = 5'($urandom_range(0, 3));
            w.b  = rand_src();
            w.c  = rand_src();
            if (k == len - 1) begin
                w.seq = SEQ_END;
            end else begin
                r = $urandom_range(0, 2);
                w.seq = (r == 0) ? SEQ_NEXT : (r == 1) ? SEQ_JUMP : SEQ_BRANCH;
                lim = (len - 2 - k < 2) ? len - 2 - k : 2;
                w.target = s + 8'(k + 1 + $urandom_range(0, lim));
`ifdef MICROSEQ_STACK_EN
                if (w.seq == SEQ_JUMP) w.cond = 2'b00;
`endif
            end
            rom[addr] = w;
        end
    endtask

    // Reference walk: a word issues one cycle after its predecessor, but no
    // sooner than HAZ+1 cycles after the last writer of a register it reads;
    // a branch also waits HAZ+1 cycles after its predecessor.
    task automatic build_expect(input logic [7:0] s, input logic [3:0] flags);
        int         lastw [32];
        int         prev, e, n;
        logic [7:0] pc;
        word_t      w;
        for (int i = 0; i < 32; i++) lastw[i] = -100;
        pc   = s;
        prev = 0;
        n    = 0;
        while (n < 500) begin
            w = rom[pc];
            e = (n == 0) ? 2 : prev + 1;
            if (!w.b[5] && w.b[4:0] != 0 && lastw[w.b[4:0]] + HAZ + 1 > e)
                e = lastw[w.b[4:0]] + HAZ + 1;
            if (!w.c[5] && w.c[4:0] != 0 && lastw[w.c[4:0]] + HAZ + 1 > e)
                e = lastw[w.c[4:0]] + HAZ + 1;
            if (w.seq == SEQ_BRANCH && n > 0 && prev + HAZ + 1 > e)
                e = prev + HAZ + 1;
            sbq.push_back('{w: w, rel: e});
            if (w.a != 0) lastw[w.a] = e;
            prev = e;
            n++;
            if (w.seq == SEQ_END) begin
                exp_done_rel = e + HAZ;
                break;
            end else if (w.seq == SEQ_NEXT) begin
                pc = pc + 8'd1;
            end else if (w.seq == SEQ_JUMP) begin
                pc = w.target;
            end else begin
                pc = flags[w.cond] ? w.target : pc + 8'd1;
            end
        end
    endtask

    task automatic launch(input logic [7:0] s, input logic [3:0] flags);
        build_expect(s, flags);
        cond_flags = flags;
        start_addr = s;
        @(negedge clock);
        check("idle_cs_addr", 64'(cs.cs_addr), 64'(s));
        check("idle_busy", 64'(busy), 64'd0);
        done_seen = 1'b0;
        armed     = 1'b1;
        start     = 1'b1;
        @(posedge clock);
        #1;
        s_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic run_prog(input logic [7:0] s, input logic [3:0] flags);
        launch(s, flags);
        for (int i = 0; i < 3000 && !done_seen; i++) @(negedge clock);
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done");
        end
        @(negedge clock);
        #1;
        check("queue_drained", 64'(sbq.size()), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("err_clear", 64'(err), 64'd0);
        sbq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear_rom();
        start_addr = 8'hA5;
        #3;
        check("reset_fields", out_fields(), 64'd0);
        check("reset_status", 64'({issue_valid, busy, done, err}), 64'd0);
        check("reset_cs_addr", 64'(cs.cs_addr), 64'hA5);
        @(negedge clock);
        reset_n = 1'b1;

        // Straight line NEXT, NEXT, END without register overlap.
        clear_rom();
        put(8'h10, SEQ_NEXT, 5'd0, 6'h21, 6'h22, 2'd0, 8'h00);
        put(8'h11, SEQ_NEXT, 5'd0, 6'h23, 6'h24, 2'd0, 8'h00);
        put(8'h12, SEQ_END,  5'd0, 6'h25, 6'h26, 2'd0, 8'h00);
        run_prog(8'h10, 4'h0);

        // RAW on register 5, then the same reader with a constant B.
        clear_rom();
        put(8'h20, SEQ_NEXT, 5'd5, 6'h20, 6'h20, 2'd0, 8'h00);
        put(8'h21, SEQ_NEXT, 5'd0, 6'h05, 6'h20, 2'd0, 8'h00);
        put(8'h22, SEQ_END,  5'd0, 6'h20, 6'h20, 2'd0, 8'h00);
        run_prog(8'h20, 4'h0);
        put(8'h21, SEQ_NEXT, 5'd0, 6'h25, 6'h20, 2'd0, 8'h00);
        run_prog(8'h20, 4'h0);

        // Branch on Z, taken and not taken.
        clear_rom();
        put(8'h30, SEQ_NEXT,   5'd1, 6'h20, 6'h20, 2'd0, 8'h00);
        put(8'h31, SEQ_BRANCH, 5'd0, 6'h20, 6'h20, 2'd0, 8'h40);
        put(8'h32, SEQ_END,    5'd0, 6'h20, 6'h20, 2'd0, 8'h00);
        put(8'h40, SEQ_END,    5'd0, 6'h20, 6'h20, 2'd0, 8'h00);
        run_prog(8'h30, 4'b0001);
        run_prog(8'h30, 4'b1110);

        // Micro-PC wrap past 0xFF.
        clear_rom();
        put(8'h50, SEQ_JUMP, 5'd0, 6'h20, 6'h20, 2'd0, 8'hFF);
        put(8'hFF, SEQ_NEXT, 5'd2, 6'h20, 6'h20, 2'd0, 8'h00);
        put(8'h00, SEQ_END,  5'd0, 6'h02, 6'h20, 2'd0, 8'h00);
        run_prog(8'h50, 4'h0);

        // Asynchronous reset in the middle of a program.
        gen_prog(8'h80, 14);
        launch(8'h80, 4'($urandom));
        repeat (6) @(negedge clock);
        #2;
        armed   = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midreset_fields", out_fields(), 64'd0);
        check("midreset_status", 64'({issue_valid, busy, done, err}), 64'd0);
        repeat (3) begin
            @(negedge clock);
            check("midreset_no_done", 64'({done, busy}), 64'd0);
        end
        reset_n = 1'b1;
        sbq.delete();

        for (int n = 0; n < 24; n++) begin
            logic [7:0] s;
            s = (n % 4 == 3) ? 8'(8'hF8 + $urandom_range(0, 7)) : 8'($urandom);
            gen_prog(s, $urandom_range(3, 16));
            run_prog(s, 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
